// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Opcode constants, default width and opcode legality check for
//            the ALU issue queue.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

   localparam int ALU_DATA_W = 8;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   function automatic logic alu_op_legal(input logic [2:0] op);
      logic legal;
      legal = 1'b0;
      case (op)
         ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: legal = 1'b1;
         default:                                    legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_fifo.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_fifo
// Brief    : DEPTH-entry FIFO storage with occupancy count, full and empty.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_fifo
   import alu_pkg::*;
#(
   parameter int WIDTH = 2*ALU_DATA_W+3,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_rdata,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int                  c_addr_w   = $clog2(DEPTH);
   localparam logic [c_addr_w-1:0] c_ptr_one  = 1;
   localparam logic [c_addr_w:0]   c_cnt_one  = 1;
   localparam logic [c_addr_w:0]   c_cnt_full = (c_addr_w+1)'(DEPTH);

   logic [WIDTH-1:0]    r_mem [DEPTH];
   logic [c_addr_w-1:0] r_wr_ptr;
   logic [c_addr_w-1:0] r_rd_ptr;
   logic [c_addr_w:0]   r_count;
   logic                w_push;
   logic                w_pop;

   assign o_full  = (r_count == c_cnt_full);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_rdata = r_mem[r_rd_ptr];

   // A full queue never accepts, even when the head leaves on the same edge.
   assign w_push = i_push & ~o_full;
   assign w_pop  = i_pop  & ~o_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_cnt_one;
            2'b01:   r_count <= r_count - c_cnt_one;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wdata;
   end

endmodule
`default_nettype wire

// File: rtl/alu_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_queue
// Brief    : Buffers ALU requests, drops illegal opcodes and issues in order
//            to a one-cycle registered ALU. Define ALU_ISSUE_BYPASS_EN to let
//            a legal request skip an empty queue when not stalled.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_queue
   import alu_pkg::*;
#(
   parameter int DATA_W = ALU_DATA_W,
   parameter int DEPTH  = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic [DATA_W-1:0]      in_a_i,
   input  logic [DATA_W-1:0]      in_b_i,
   input  logic [2:0]             in_op_i,
   input  logic                   alu_stall_i,
   output logic                   alu_en_o,
   output logic [DATA_W-1:0]      alu_a_o,
   output logic [DATA_W-1:0]      alu_b_o,
   output logic [2:0]             alu_op_o,
   output logic                   rsp_valid_o,
   output logic                   err_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int c_entry_w = 2*DATA_W + 3;

   logic                 w_full;
   logic                 w_empty;
   logic                 w_accept;
   logic                 w_legal;
   logic                 w_bypass;
   logic                 w_push;
   logic                 w_pop;
   logic [c_entry_w-1:0] w_head;

   logic                 r_en;
   logic                 r_rsp;
   logic                 r_err;
   logic [DATA_W-1:0]    r_a;
   logic [DATA_W-1:0]    r_b;
   logic [2:0]           r_op;

   assign in_ready_o = rst_ni & ~w_full;
   assign w_accept   = in_valid_i & in_ready_o;
   assign w_legal    = alu_op_legal(in_op_i);
   assign w_pop      = ~w_empty & ~alu_stall_i;

`ifdef ALU_ISSUE_BYPASS_EN
   assign w_bypass   = w_accept & w_legal & w_empty & ~alu_stall_i;
`else
   assign w_bypass   = 1'b0;
`endif

   assign w_push     = w_accept & w_legal & ~w_bypass;

   alu_issue_fifo #(
      .WIDTH (c_entry_w),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk_i),
      .rst_n   (rst_ni),
      .i_push  (w_push),
      .i_wdata ({in_op_i, in_b_i, in_a_i}),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_count (count_o),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Operand registers only move on an issue so the ALU inputs stay stable.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_en  <= 1'b0;
         r_rsp <= 1'b0;
         r_err <= 1'b0;
         r_a   <= '0;
         r_b   <= '0;
         r_op  <= '0;
      end else begin
         r_en  <= w_pop | w_bypass;
         r_rsp <= r_en;
         r_err <= w_accept & ~w_legal;
         if (w_pop) begin
            {r_op, r_b, r_a} <= w_head;
         end else if (w_bypass) begin
            r_a  <= in_a_i;
            r_b  <= in_b_i;
            r_op <= in_op_i;
         end
      end
   end

   assign alu_en_o    = r_en;
   assign rsp_valid_o = r_rsp;
   assign err_o       = r_err;
   assign alu_a_o     = r_a;
   assign alu_b_o     = r_b;
   assign alu_op_o    = r_op;

endmodule
`default_nettype wire

// File: doc/alu_issue_queue.md
ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk_i and rst_ni.
REQ-002 Parameter DATA_W, default 8, SHALL set the operand width.
REQ-003 Parameter DEPTH, default 4, SHALL set the queue depth; it SHALL be a power of two, at least 2.
REQ-004 Ports SHALL be, in this order:
- clk_i  in  1  clock; all state on rising edge.
- rst_ni  in  1  async active-low reset.
- in_valid_i  in  1  upstream request valid.
- in_ready_o  out  1  queue can accept.
- in_a_i  in  DATA_W  operand A.
- in_b_i  in  DATA_W  operand B.
- in_op_i  in  3  ALU operation code.
- alu_stall_i  in  1  downstream hold; no issue while high.
- alu_en_o  out  1  one-cycle issue strobe to RegisteredALU en_i.
- alu_a_o  out  DATA_W  to ALU a_i.
- alu_b_o  out  DATA_W  to ALU b_i.
- alu_op_o  out  3  to ALU operation_i.
- rsp_valid_o  out  1  ALU result_o/zero_o valid this cycle.
- err_o  out  1  one-cycle pulse on rejected illegal opcode.
- count_o  out  $clog2(DEPTH)+1  entries held.

Function
REQ-005 Legal opcodes SHALL be 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; all others are illegal.
REQ-006 A transfer SHALL occur on a rising edge with in_valid_i and in_ready_o both high.
REQ-007 in_ready_o SHALL be high exactly when count_o < DEPTH and rst_ni is high.
REQ-008 A transfer with an illegal opcode SHALL be consumed, SHALL NOT be enqueued, and SHALL pulse err_o high for the following cycle.
REQ-009 A legal transfer SHALL be enqueued at the tail, in FIFO order.
REQ-010 An issue SHALL occur on an edge where count_o > 0 and alu_stall_i is low: head popped into alu_a_o/alu_b_o/alu_op_o; alu_en_o high for the following cycle.
REQ-011 alu_a_o, alu_b_o and alu_op_o SHALL hold their last issued values when no issue occurs.
REQ-012 alu_en_o SHALL be low in any cycle following an edge with no issue.
REQ-013 rsp_valid_o SHALL equal alu_en_o delayed by exactly one cycle, matching the ALU's one-cycle registered latency.
REQ-014 A push and a pop on the same edge SHALL leave count_o unchanged.
REQ-015 No push SHALL occur while full, including on an edge that also pops; no full-queue pass-through.
REQ-016 Pointers SHALL wrap modulo DEPTH with no entry lost or duplicated.
REQ-017 Without bypass, latency from the accept edge to alu_en_o high SHALL be 2 cycles with an empty queue and no stall.
REQ-018 alu_stall_i high SHALL freeze the queue head; pushes SHALL continue until full.

Reset
REQ-019 Asserting rst_ni low SHALL immediately clear count_o, pointers, alu_en_o, rsp_valid_o, err_o, alu_a_o, alu_b_o and alu_op_o to zero, and force in_ready_o low.
REQ-020 Reset mid-operation SHALL discard all queued and in-flight entries; no rsp_valid_o SHALL follow for them.
REQ-021 The first transfer SHALL be possible on the first rising edge after rst_ni deasserts.

Configuration
REQ-022 Macro ALU_ISSUE_BYPASS_EN, when defined, SHALL issue a legal accepted entry directly to the ALU outputs on its accept edge when the queue is empty and alu_stall_i is low: count_o stays 0 and latency is 1 cycle.
REQ-023 When ALU_ISSUE_BYPASS_EN is undefined, every entry SHALL pass through queue storage, per REQ-017.

Structure
REQ-024 Package alu_pkg SHALL hold the opcode constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT), the default data width, and an opcode-legality function.
REQ-025 Storage SHALL be a sub-module alu_issue_fifo (DEPTH x (2*DATA_W+3), count/full/empty); issue, strobe and response logic SHALL be in the top module.

Verification
REQ-026 Reset with rst_ni low mid-stream -> all outputs 0 and in_ready_o 0 immediately; after release, count_o=0.
REQ-027 Push a=0x3A, b=0x19, op=010, then op=110, no stall -> ALU result 0x53 then 0x21, zero=0, each one cycle after its rsp_valid_o edge.
REQ-028 Push a=0x00, b=0x00, op=010 -> rsp_valid_o with ALU result 0x00, zero=1; latency 2 cycles (1 with ALU_ISSUE_BYPASS_EN).
REQ-029 alu_stall_i high, push 5 entries, DEPTH=4 -> in_ready_o low after the 4th; count_o=4; release stall -> 4 issues in order on consecutive cycles.
REQ-030 Push op=011 -> err_o pulses once, count_o unchanged, no alu_en_o.
REQ-031 Continuous push/pop for 10 entries (a=0x0E, b=0x19 alternating 010/110) -> count_o constant, pointers wrap, issued order matches pushed order (0x27, 0xF5 pattern).
